ro_capture_ctrl: RTL and testbench
==================================

Name: ro_capture_ctrl

Overview:
- Sequencer for the dual ring-oscillator entropy buffer.
- On request it:
  - enables both ring oscillators;
  - waits a warm-up period, then waits until the 64-bit XOR shift register is full;
  - steps the buffer's 3-bit byte select through consecutive indices;
  - captures one byte per step into a holding register;
  - hands each byte to a consumer over a valid/ready handshake, with a configurable gap between captures so each byte carries fresh bits.
- Sits between the entropy buffer and the chip-level I/O / register logic.

Parameters:
- WARMUP_CYCLES, 16: cycles the oscillators run before collection starts (min 1).
- FILL_CYCLES, 66: cycles allowed for the 64-bit shift register to fill, including the 2-stage capture path (min 1).
- SEL_LAT, 2: cycles from an out_sel change to a stable buffer byte (min 1).
- GAP_CYCLES, 8: cycles between a completed handshake and the next select step (min 1).
- NUM_BYTES, 8: bytes delivered per request (1..255).
- CNT_W, 8: width of the internal delay counter; must hold max(parameter) - 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: request a capture run; sampled only in IDLE.
- abort, input, 1: synchronous abort, highest priority.
- trng_byte_in, input, 8: byte from the entropy buffer's out port.
- byte_ready, input, 1: consumer accepts byte_out.
- ro_activate_1, output, 1: enable for oscillator 1.
- ro_activate_2, output, 1: enable for oscillator 2.
- out_sel, output, 3: byte select to the entropy buffer.
- byte_out, output, 8: captured byte.
- byte_valid, output, 1: byte_out valid.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse at end of run.

Behaviour:
- Interface rule: one clock (clk); reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: every output is 0, state = IDLE, all counters = 0.
- Delay counter: each timed state loads N-1 on entry and lasts exactly N cycles; it exits when the count reaches 0.

States:
- IDLE:
  - ro_activate_1/2 = 0, busy = 0.
  - start = 1 moves to WARMUP; out_sel and the byte index clear to 0.
- WARMUP (WARMUP_CYCLES): ro_activate_1/2 = 1, busy = 1; then goes to FILL.
- FILL (FILL_CYCLES): oscillators remain enabled; then goes to SELECT.
- SELECT (SEL_LAT): out_sel holds the current index. On exit, byte_out <= trng_byte_in and byte_valid <= 1; then goes to HOLD.
- HOLD:
  - byte_valid = 1; byte_out is stable and must not change while valid.
  - On byte_valid & byte_ready: byte_valid <= 0 and the byte index increments.
  - If that was byte NUM_BYTES-1, go to DONE; otherwise out_sel <= out_sel+1 (wraps 7 to 0) and go to GAP.
- GAP (GAP_CYCLES): oscillators stay enabled; then goes to SELECT.
- DONE (1 cycle): done = 1, ro_activate_1/2 <= 0, busy <= 0; then goes to IDLE.

Latency and handshake:
- The first byte_valid rises WARMUP_CYCLES+FILL_CYCLES+SEL_LAT cycles after the edge that samples start.
- Back-to-back bytes: valid-to-valid spacing is GAP_CYCLES+SEL_LAT+1 cycles when ready is held high.
- byte_ready outside HOLD is ignored. byte_ready high on the first HOLD cycle completes the handshake in that cycle.
- byte_out keeps its last captured value after the run ends; it is only updated on capture.

Boundary conditions:
- start while busy is ignored; there is no queuing.
- start and abort high together in IDLE: abort wins and the state stays IDLE.
- abort in any non-IDLE state, next cycle:
  - state = IDLE;
  - ro_activate_1/2 = 0, byte_valid = 0, busy = 0, out_sel = 0;
  - no done pulse;
  - byte_out is retained.
- NUM_BYTES > 8: out_sel wraps 7 to 0 and continues.
- NUM_BYTES = 1: HOLD goes straight to DONE.
- Reset asserted mid-run: immediate asynchronous return to reset values; ROs are disabled combinationally by the register reset.
- Out-of-range parameters are not required to be detected.

Test Plan:
- Reset, defaults: assert rst_n=0 mid-HOLD -> all outputs 0 immediately. Release, pulse start at edge E -> ro_activate_1/2 rise at E+1, first byte_valid at E+84, out_sel=0 during the first SELECT.
- Full run, byte_ready tied 1, trng_byte_in driven = 8'hA0+out_sel (model adds 1-cycle lag) -> bytes A0..A7 captured, valid pulses 11 cycles apart, done pulses once, busy falls with done, ro_activate low after DONE.
- Backpressure: byte_ready held 0 for 20 cycles on byte 3 -> byte_valid stays 1, byte_out stable at 8'hA3, out_sel stays 3; ready=1 -> GAP entered, next valid after 11 cycles.
- Abort during FILL and during HOLD -> next cycle IDLE, busy=0, byte_valid=0, ro_activate=0, done never pulses; a later start runs a full sequence normally.
- NUM_BYTES=10 -> out_sel sequence 0..7,0,1; exactly 10 handshakes; one done pulse.
- start asserted while busy, and start+abort together in IDLE -> no restart or extra bytes in either case; state remains IDLE for the simultaneous case.

Source files
------------

// File: rtl/ro_capture_ctrl.sv
// Capture sequencer for the dual ring-oscillator entropy buffer: warms up the
// oscillators, waits for the shift register to fill, then hands out bytes.
module ro_capture_ctrl #(
  parameter int WARMUP_CYCLES = 16,
  parameter int FILL_CYCLES   = 66,
  parameter int SEL_LAT       = 2,
  parameter int GAP_CYCLES    = 8,
  parameter int NUM_BYTES     = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] trng_byte_in,
  input  logic       byte_ready,
  output logic       ro_activate_1,
  output logic       ro_activate_2,
  output logic [2:0] out_sel,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_FILL, S_SELECT, S_HOLD, S_GAP, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LD = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEL_LD  = CNT_W'(SEL_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       LAST_IX = 8'(NUM_BYTES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       byte_q, byte_d;
  logic             vld_q, vld_d;
  logic             ro_q, ro_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             running;

  // Status outputs follow the state one cycle later, so they drop together
  // with the done pulse when the run closes.
  assign running = (state_q == S_WARMUP) || (state_q == S_FILL) ||
                   (state_q == S_SELECT) || (state_q == S_HOLD) ||
                   (state_q == S_GAP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    byte_d  = byte_q;
    vld_d   = vld_q;
    ro_d    = !abort && running;
    busy_d  = !abort && running;
    done_d  = !abort && (state_q == S_DONE);
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
      if (state_q != S_IDLE) sel_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          state_d = S_WARMUP;
          cnt_d   = WARM_LD;
          sel_d   = '0;
          idx_d   = '0;
        end
        S_WARMUP: begin
          if (cnt_q == '0) begin
            state_d = S_FILL;
            cnt_d   = FILL_LD;
          end else cnt_d = cnt_q - 1'b1;
        end
        S_FILL: begin
          if (cnt_q == '0) begin
            state_d = S_SELECT;
            cnt_d   = SEL_LD;
          end else cnt_d = cnt_q - 1'b1;
        end
        S_SELECT: begin
          if (cnt_q == '0) begin
            state_d = S_HOLD;
            byte_d  = trng_byte_in;
            vld_d   = 1'b1;
          end else cnt_d = cnt_q - 1'b1;
        end
        S_HOLD: if (byte_ready) begin
          vld_d = 1'b0;
          idx_d = idx_q + 8'd1;
          if (idx_q == LAST_IX) state_d = S_DONE;
          else begin
            sel_d   = sel_q + 3'd1;
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_SELECT;
            cnt_d   = SEL_LD;
          end else cnt_d = cnt_q - 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      ro_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      ro_q    <= ro_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ro_activate_1 = ro_q;
  assign ro_activate_2 = ro_q;
  assign out_sel       = sel_q;
  assign byte_out      = byte_q;
  assign byte_valid    = vld_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ro_capture_ctrl.sv
// Directed bench for ro_capture_ctrl: default build plus a 10-byte build.
module tb_ro_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 0, abort = 0, rdy = 0;
  logic [7:0] trng = 8'h00;
  logic       ro1, ro2, vld, busy, done;
  logic [2:0] sel;
  logic [7:0] bo;

  logic       start10 = 0, rdy10 = 1;
  logic [7:0] trng10 = 8'h00;
  logic       ro1_10, ro2_10, vld10, busy10, done10;
  logic [2:0] sel10;
  logic [7:0] bo10;

  ro_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .trng_byte_in(trng), .byte_ready(rdy),
    .ro_activate_1(ro1), .ro_activate_2(ro2), .out_sel(sel),
    .byte_out(bo), .byte_valid(vld), .busy(busy), .done(done));

  ro_capture_ctrl #(.NUM_BYTES(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .abort(1'b0),
    .trng_byte_in(trng10), .byte_ready(rdy10),
    .ro_activate_1(ro1_10), .ro_activate_2(ro2_10), .out_sel(sel10),
    .byte_out(bo10), .byte_valid(vld10), .busy(busy10), .done(done10));

  // Entropy buffer model: selected byte appears one cycle after out_sel.
  always @(posedge clk) begin
    trng   <= 8'hA0 + {5'b0, sel};
    trng10 <= 8'hA0 + {5'b0, sel10};
  end

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, hs_cnt = 0, done10_cnt = 0, hs10_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (vld && rdy) hs_cnt++;
    if (done10) done10_cnt++;
    if (vld10 && rdy10) hs10_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    do begin tick(); c++; end while (!vld && c < 300);
  endtask

  task automatic wait_valid10(output int c);
    c = 0;
    do begin tick(); c++; end while (!vld10 && c < 300);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 2000) begin tick(); c++; end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ro1"}, ro1, 0);
    chk({tag, "_ro2"}, ro2, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_sel"}, sel, 0);
  endtask

  initial begin
    int c, d0, h0;
    logic [7:0] exp_b;

    // Reset state
    repeat (2) tick();
    chk_idle("rst");
    chk("rst_bo", bo, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    tick();

    // Full run with ready tied high
    rdy = 1;
    start = 1;
    tick();                       // edge E sampled start
    start = 0;
    chk("a_ro_e0", ro1, 0);
    tick();
    chk("a_ro1_e1", ro1, 1);
    chk("a_ro2_e1", ro2, 1);
    chk("a_busy_e1", busy, 1);
    wait_valid(c);
    chk("a_first_lat", c, 83);    // 84 edges after E, one already consumed
    chk("a_sel0", sel, 0);
    chk("a_b0", bo, 8'hA0);
    for (int k = 1; k < 8; k++) begin
      wait_valid(c);
      exp_b = 8'hA0 + 8'(k);
      chk("a_gap", c, 11);
      chk("a_byte", bo, exp_b);
      chk("a_sel", sel, k);
    end
    tick();
    chk("a_busy_hs7", busy, 1);
    tick();
    chk("a_done", done, 1);
    chk("a_busy_end", busy, 0);
    chk("a_ro_end", ro1, 0);
    tick();
    chk("a_done_pulse", done, 0);
    chk("a_bo_keep", bo, 8'hA7);
    chk("a_hs_cnt", hs_cnt, 8);
    chk("a_done_cnt", done_cnt, 1);

    // Backpressure on byte 3, plus start while busy
    d0 = done_cnt; h0 = hs_cnt;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) wait_valid(c);
    tick();                       // byte 2 handshake
    rdy = 0;
    wait_valid(c);
    chk("b_gap3", c, 10);
    for (int k = 0; k < 20; k++) begin
      chk("b_hold_vld", vld, 1);
      chk("b_hold_bo", bo, 8'hA3);
      chk("b_hold_sel", sel, 3);
      start = (k == 5);
      tick();
    end
    start = 0;
    chk("b_nostart_sel", sel, 3);
    rdy = 1;
    tick();
    chk("b_vld_drop", vld, 0);
    wait_valid(c);
    chk("b_gap4", c, 10);
    chk("b_b4", bo, 8'hA4);
    wait_done(c);
    chk("b_done_seen", done, 1);
    tick();
    chk("b_hs_cnt", hs_cnt - h0, 8);
    chk("b_done_cnt", done_cnt - d0, 1);
    chk("b_bo_last", bo, 8'hA7);

    // start and abort together in IDLE
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    repeat (4) tick();
    chk("c_sa_busy", busy, 0);
    chk("c_sa_ro", ro1, 0);

    // Abort during FILL
    d0 = done_cnt; h0 = hs_cnt;
    start = 1; tick(); start = 0;
    repeat (30) tick();
    chk("d_fill_busy_pre", busy, 1);
    abort = 1; tick(); abort = 0;
    chk_idle("d_fill");
    repeat (100) tick();
    chk("d_fill_vld", vld, 0);
    chk("d_fill_done", done_cnt - d0, 0);

    // Abort during HOLD of byte 1
    start = 1; tick(); start = 0;
    wait_valid(c);
    tick();
    rdy = 0;
    wait_valid(c);
    chk("d_hold_b1", bo, 8'hA1);
    repeat (3) tick();
    abort = 1; tick(); abort = 0;
    chk_idle("d_hold");
    chk("d_hold_bo", bo, 8'hA1);
    repeat (5) tick();
    chk("d_hold_done", done_cnt - d0, 0);
    chk("d_hold_hs", hs_cnt - h0, 1);

    // Normal run after the aborts
    d0 = done_cnt; h0 = hs_cnt;
    rdy = 1;
    start = 1; tick(); start = 0;
    wait_done(c);
    tick();
    chk("e_hs_cnt", hs_cnt - h0, 8);
    chk("e_done_cnt", done_cnt - d0, 1);
    chk("e_bo", bo, 8'hA7);

    // NUM_BYTES=10: out_sel wraps
    start10 = 1; tick(); start10 = 0;
    for (int k = 0; k < 10; k++) begin
      wait_valid10(c);
      exp_b = 8'hA0 + 8'(k % 8);
      chk("f_sel", sel10, k % 8);
      chk("f_byte", bo10, exp_b);
    end
    repeat (4) tick();
    chk("f_hs_cnt", hs10_cnt, 10);
    chk("f_done_cnt", done10_cnt, 1);
    chk("f_busy", busy10, 0);

    // Asynchronous reset mid-HOLD
    rdy = 0;
    start = 1; tick(); start = 0;
    wait_valid(c);
    chk("g_vld_pre", vld, 1);
    #2 rst_n = 0;
    #1;
    chk_idle("g_rst");
    chk("g_rst_bo", bo, 0);
    chk("g_rst_done", done, 0);
    tick();
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
